// File: rtl/viterbi_acs_unit_if.sv
// Symbol handshake between the hard-decision demapper and the ACS stage.
// A symbol transfers on any rising edge where in_valid && in_ready.
interface viterbi_acs_unit_if;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       in_ready;

  modport master (output in_valid, output in_sym, input in_ready);
  modport slave  (input in_valid, input in_sym, output in_ready);
endinterface

// File: rtl/viterbi_acs_unit.sv
// 4-state K=3 rate-1/2 Viterbi add-compare-select with survivor registers and
// the frame controller that freezes the survivors for the traceback mapper.
module viterbi_acs_unit #(
  parameter int PM_W = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  viterbi_acs_unit_if.slave  sym_if,
  output logic [7:0]         sr00,
  output logic [7:0]         sr01,
  output logic [7:0]         sr10,
  output logic [7:0]         sr11,
  output logic [1:0]         min_state,
  output logic               te,
  output logic [2:0]         trace_ptr,
  output logic [1:0]         NEXT_STATE
);

  localparam logic [PM_W-1:0] PM_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACS           = 2'b00,
    ST_WRITE_METRICS = 2'b01,
    ST_TRACEBACK     = 2'b10,
    ST_NORM          = 2'b11
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sym_cnt_reg;
  logic [2:0]      trace_ptr_reg;
  logic [PM_W-1:0] pm_reg [4];
  logic [7:0]      sr_reg [4];

  logic [PM_W-1:0] acs_pm  [4];
  logic            acs_dec [4];
  logic [PM_W-1:0] acs_min;
  logic [PM_W-1:0] min_val;
  logic            accept;

  assign accept          = sym_if.in_valid && (state_reg == ST_ACS);
  assign sym_if.in_ready = (state_reg == ST_ACS);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_acs
      // State {s1,s0}: predecessors are {0,s1} and {1,s1}; d is the bit
      // leaving the encoder register on this branch.
      localparam logic S1 = 1'((gi >> 1) % 2);
      localparam logic S0 = 1'(gi % 2);
      localparam int   P0 = gi >> 1;
      localparam int   P1 = 2 + (gi >> 1);
      localparam logic [PM_W-1:0] PM_RST = (gi == 0) ? '0 : PM_MAX;

      logic [1:0]      bm0, bm1;
      logic [PM_W:0]   sum0, sum1;
      logic [PM_W-1:0] cand0, cand1;

      assign bm0 = {1'b0, sym_if.in_sym[1] ^ S0 ^ S1}
                 + {1'b0, sym_if.in_sym[0] ^ S0};
      assign bm1 = {1'b0, sym_if.in_sym[1] ^ S0 ^ S1 ^ 1'b1}
                 + {1'b0, sym_if.in_sym[0] ^ S0 ^ 1'b1};

      assign sum0  = {1'b0, pm_reg[P0]} + {{(PM_W-1){1'b0}}, bm0};
      assign sum1  = {1'b0, pm_reg[P1]} + {{(PM_W-1){1'b0}}, bm1};
      assign cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
      assign cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];

      // Ties keep the d=0 branch.
      assign acs_dec[gi] = (cand1 < cand0);
      assign acs_pm[gi]  = acs_dec[gi] ? cand1 : cand0;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          pm_reg[gi] <= PM_RST;
          sr_reg[gi] <= 8'h00;
        end else if (accept) begin
          pm_reg[gi] <= acs_pm[gi] - acs_min;
          sr_reg[gi] <= {sr_reg[gi][6:0], acs_dec[gi]};
        end
      end
    end
  endgenerate

  always_comb begin
    acs_min = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < acs_min) acs_min = acs_pm[i];
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_state = 2'd0;
    min_val   = pm_reg[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_reg[i] < min_val) begin
        min_val   = pm_reg[i];
        min_state = 2'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACS:           if (accept && sym_cnt_reg == 3'd7) state_next = ST_NORM;
      ST_NORM:          state_next = ST_WRITE_METRICS;
      ST_WRITE_METRICS: state_next = ST_TRACEBACK;
      ST_TRACEBACK:     if (trace_ptr_reg == 3'd7) state_next = ST_ACS;
      default:          state_next = ST_ACS;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_ACS;
      sym_cnt_reg   <= 3'd0;
      trace_ptr_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (accept) sym_cnt_reg <= sym_cnt_reg + 3'd1;
      if (state_reg == ST_WRITE_METRICS) trace_ptr_reg <= 3'd0;
      else if (state_reg == ST_TRACEBACK) trace_ptr_reg <= trace_ptr_reg + 3'd1;
    end
  end

  assign NEXT_STATE = state_next;
  assign te         = (state_reg == ST_TRACEBACK);
  assign trace_ptr  = trace_ptr_reg;
  assign sr00       = sr_reg[0];
  assign sr01       = sr_reg[1];
  assign sr10       = sr_reg[2];
  assign sr11       = sr_reg[3];

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Randomised bench for viterbi_acs_unit: a frame-position and trellis model
// is compared against every output on each falling clock edge.
module tb_viterbi_acs_unit;

  localparam int PM_W   = 3;
  localparam int PM_MAX = (1 << PM_W) - 1;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sr00, sr01, sr10, sr11;
  logic [1:0] min_state;
  logic       te;
  logic [2:0] trace_ptr;
  logic [1:0] NEXT_STATE;

  viterbi_acs_unit_if sym_if ();

  viterbi_acs_unit #(.PM_W(PM_W)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .sym_if     (sym_if),
    .sr00       (sr00),
    .sr01       (sr01),
    .sr10       (sr10),
    .sr11       (sr11),
    .min_state  (min_state),
    .te         (te),
    .trace_ptr  (trace_ptr),
    .NEXT_STATE (NEXT_STATE)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Model: metrics, survivors, accepted symbols in the frame, and position
  // after the 8th accept (0 = accepting, 1 = NORM, 2 = WRITE, 3..10 = traceback).
  int         m_pm [4];
  logic [7:0] m_sr [4];
  int         m_acc;
  int         m_post;

  task automatic model_reset();
    m_pm[0] = 0;
    for (int s = 1; s < 4; s++) m_pm[s] = PM_MAX;
    for (int s = 0; s < 4; s++) m_sr[s] = 8'h00;
    m_acc  = 0;
    m_post = 0;
  endtask

  task automatic model_acs(input logic [1:0] sym);
    int   nxt [4];
    logic dec [4];
    int   mn;
    for (int s = 0; s < 4; s++) begin
      int u, s1, best;
      u  = s % 2;
      s1 = s / 2;
      best = 0;
      dec[s] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        // Encoder register holds (u, s1, d); g0 taps all three, g1 taps u and d.
        int c0, c1, bm, cand;
        c0 = u ^ s1 ^ d;
        c1 = u ^ d;
        bm = ((sym[1] ^ c0[0]) ? 1 : 0) + ((sym[0] ^ c1[0]) ? 1 : 0);
        cand = m_pm[d * 2 + s1] + bm;
        if (cand > PM_MAX) cand = PM_MAX;
        if (d == 0 || cand < best) begin
          best   = cand;
          dec[s] = (d == 1);
        end
      end
      nxt[s] = best;
    end
    mn = nxt[0];
    for (int s = 1; s < 4; s++) if (nxt[s] < mn) mn = nxt[s];
    for (int s = 0; s < 4; s++) begin
      m_pm[s] = nxt[s] - mn;
      m_sr[s] = {m_sr[s][6:0], dec[s]};
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (m_post == 0) begin
      if (sym_if.in_valid) begin
        model_acs(sym_if.in_sym);
        m_acc++;
        if (m_acc == 8) begin
          m_acc  = 0;
          m_post = 1;
        end
      end
    end else begin
      m_post = (m_post == 10) ? 0 : m_post + 1;
    end
  end

  function automatic int model_next_state();
    if (m_post == 0) return (sym_if.in_valid && m_acc == 7) ? 3 : 0;
    if (m_post == 1) return 1;
    if (m_post == 10) return 0;
    return 2;
  endfunction

  function automatic int model_min_state();
    int idx = 0;
    for (int s = 1; s < 4; s++) if (m_pm[s] < m_pm[idx]) idx = s;
    return idx;
  endfunction

  always @(negedge clock) begin
    check("in_ready",   sym_if.in_ready, (m_post == 0) ? 1 : 0);
    check("te",         te, (m_post >= 3) ? 1 : 0);
    check("trace_ptr",  trace_ptr, (m_post >= 3) ? m_post - 3 : 0);
    check("NEXT_STATE", NEXT_STATE, model_next_state());
    check("min_state",  min_state, model_min_state());
    check("sr00", sr00, m_sr[0]);
    check("sr01", sr01, m_sr[1]);
    check("sr10", sr10, m_sr[2]);
    check("sr11", sr11, m_sr[3]);
  end

  function automatic logic [7:0] dut_sr(input int idx);
    case (idx)
      0:       return sr00;
      1:       return sr01;
      2:       return sr10;
      default: return sr11;
    endcase
  endfunction

  task automatic step(input logic v, input logic [1:0] s);
    @(posedge clock);
    #2;
    sym_if.in_valid = v;
    sym_if.in_sym   = s;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      step(1'b0, 2'b00);
      #1;
      if (sym_if.in_ready) ok = 1'b1;
    end
    check("wait_ready_timeout", ok, 1'b1);
  endtask

  initial begin
    logic [1:0] enc [8];
    int te_cnt, low_cnt, st;
    logic [7:0] recovered;
    bit found;

    sym_if.in_valid = 1'b0;
    sym_if.in_sym   = 2'b00;
    model_reset();

    // Reset values while rst_n is held low.
    repeat (3) step(1'b0, 2'b00);
    #1;
    check("rst_in_ready",  sym_if.in_ready, 1);
    check("rst_te",        te, 0);
    check("rst_min_state", min_state, 0);
    check("rst_sr00",      sr00, 8'h00);
    check("rst_sr11",      sr11, 8'h00);

    // All-zero frame from reset.
    step(1'b0, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    #1;
    check("zero_next_state_write", NEXT_STATE, 2'b01);
    check("zero_min_state",        min_state, 0);
    check("zero_sr00",             sr00, 8'h00);
    check("zero_in_ready_norm",    sym_if.in_ready, 0);
    te_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00);
      #1;
      if (te) begin
        check("zero_te_ptr_seq", trace_ptr, te_cnt);
        te_cnt++;
      end
    end
    check("zero_te_cycles", te_cnt, 8);
    check("zero_back_to_acs", sym_if.in_ready, 1);

    // Encoded single 1: 11,10,11 then zeros; trace back from state 00.
    enc[0] = 2'b11; enc[1] = 2'b10; enc[2] = 2'b11;
    for (int k = 3; k < 8; k++) enc[k] = 2'b00;
    for (int k = 0; k < 8; k++) step(1'b1, enc[k]);
    step(1'b0, 2'b00);
    #1;
    check("enc_min_state", min_state, 0);
    st = 0;
    recovered = 8'h00;
    for (int t = 8; t >= 1; t--) begin
      logic [7:0] srv;
      int d;
      srv = dut_sr(st);
      recovered[t-1] = st[0];
      d  = srv[8-t] ? 1 : 0;
      st = d * 2 + st / 2;
    end
    check("enc_traceback_bits", recovered, 8'h01);
    wait_ready();

    // Stall: each accept followed by two idle cycles.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)));
      step(1'b0, 2'($urandom_range(0, 3)));
      step(1'b0, 2'($urandom_range(0, 3)));
    end
    wait_ready();

    // Back-pressure: in_valid held high across the whole non-ACS window.
    low_cnt = 0;
    for (int j = 0; j < 26; j++) begin
      step(1'b1, 2'($urandom_range(0, 3)));
      #1;
      if (!sym_if.in_ready) low_cnt++;
      if (j == 18) check("bp_resume_cycle19", sym_if.in_ready, 1);
    end
    check("bp_ready_low_cycles", low_cnt, 10);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));

    // Reset in the middle of traceback.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)));
      #1;
      if (te && trace_ptr == 3'd4) found = 1'b1;
    end
    check("midrst_reach_ptr4", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_te",         te, 0);
    check("midrst_trace_ptr",  trace_ptr, 0);
    check("midrst_in_ready",   sym_if.in_ready, 1);
    check("midrst_next_state", NEXT_STATE, 0);
    check("midrst_sr00",       sr00, 8'h00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 2'($urandom_range(0, 3)));
    step(1'b0, 2'b00);
    #1;
    check("midrst_frame_8_accepts", NEXT_STATE, 2'b01);
    wait_ready();
    repeat (3) step(1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
